// File: rtl/qcw_pkg.sv
// Shared types and widths for the QCW pulse sequencer.
// Pure declarations; no logic, no latency, no flow control.
// Consumers import qcw_pkg::* for the state enum and default widths.
package qcw_pkg;

    localparam int QCW_LEVEL_W = 10;
    localparam int QCW_CNT_W   = 24;
    localparam int QCW_RATE_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_HOLDOFF,
        S_FAULT
    } qcw_seq_state_t;

endpackage

// File: rtl/qcw_ramp_gen.sv
// Saturating fixed-point ramp accumulator; level is the registered integer part.
// Latency: load/step visible on level one cycle after the enabling edge.
// No backpressure: steps every enabled cycle, clamps at all-ones instead of wrapping.
module qcw_ramp_gen
    import qcw_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic                   system_clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   enable,
    input  logic [QCW_LEVEL_W-1:0] init,
    input  logic [QCW_RATE_W-1:0]  rate,
    output logic [QCW_LEVEL_W-1:0] level
);

    localparam int ACC_W = QCW_LEVEL_W + FRAC;

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // One spare carry bit tells us the add would have wrapped.
    assign sum = {1'b0, acc} + {{(ACC_W + 1 - QCW_RATE_W){1'b0}}, rate};

    always_ff @(posedge system_clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(init) << FRAC;
        end else if (enable) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

    assign level = acc[ACC_W-1 -: QCW_LEVEL_W];

endmodule

// File: rtl/qcw_pulse_ctrl.sv
// QCW burst sequencer: trigger edge -> ARM -> RUN (bridge on, ramp) -> HOLDOFF -> IDLE.
// Latency: trigger edge to qcw_start 2 cycles, qcw_start to bridge_en 1 cycle; halt drops bridge next cycle.
// No backpressure: edges outside IDLE are dropped. QCW_FAULT_LATCH_EN makes a halt latch fault until fault_clear.
module qcw_pulse_ctrl
    import qcw_pkg::*;
#(
    parameter int CNT_W     = QCW_CNT_W,
    parameter int RAMP_FRAC = 8
) (
    input  logic                   system_clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [CNT_W-1:0]       pulse_len,
    input  logic [CNT_W-1:0]       holdoff_len,
    input  logic [QCW_LEVEL_W-1:0] ramp_init,
    input  logic [QCW_RATE_W-1:0]  ramp_rate,
    input  logic                   qcw_halt,
    input  logic                   fault_clear,
    output logic                   qcw_start,
    output logic                   qcw_done,
    output logic                   bridge_en,
    output logic [QCW_LEVEL_W-1:0] ramp_level,
    output logic                   busy,
    output logic                   fault
);

    qcw_seq_state_t state;

    logic                   trig_q;
    logic                   trig_edge;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       pulse_lat;
    logic [CNT_W-1:0]       holdoff_lat;
    logic [QCW_LEVEL_W-1:0] init_lat;
    logic [QCW_RATE_W-1:0]  rate_lat;
    logic [QCW_LEVEL_W-1:0] ramp_raw;

`ifndef QCW_FAULT_LATCH_EN
    logic unused_fault_clear;
    assign unused_fault_clear = fault_clear;
`endif

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            trig_q      <= 1'b1;   // a level already high at release is not an edge
            trig_edge   <= 1'b0;
            cnt         <= '0;
            pulse_lat   <= '0;
            holdoff_lat <= '0;
            init_lat    <= '0;
            rate_lat    <= '0;
            qcw_start   <= 1'b0;
            qcw_done    <= 1'b0;
            bridge_en   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            trig_q    <= trigger;
            // Only edges that land while idle are kept; anything else is dropped.
            trig_edge <= trigger & ~trig_q & (state == S_IDLE);
            qcw_start <= 1'b0;
            qcw_done  <= 1'b0;
`ifndef QCW_FAULT_LATCH_EN
            fault     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (trig_edge && (pulse_len != '0) && !fault) begin
                        pulse_lat   <= pulse_len;
                        holdoff_lat <= holdoff_len;
                        init_lat    <= ramp_init;
                        rate_lat    <= ramp_rate;
                        qcw_start   <= 1'b1;
                        state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    cnt       <= pulse_lat - 1'b1;
                    bridge_en <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (qcw_halt) begin
                        bridge_en <= 1'b0;
                        qcw_done  <= 1'b1;
                        fault     <= 1'b1;
`ifdef QCW_FAULT_LATCH_EN
                        state     <= S_FAULT;
`else
                        cnt       <= holdoff_lat;
                        state     <= S_HOLDOFF;
`endif
                    end else if (cnt == '0) begin
                        bridge_en <= 1'b0;
                        qcw_done  <= 1'b1;
                        cnt       <= holdoff_lat;
                        state     <= S_HOLDOFF;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FAULT: begin
`ifdef QCW_FAULT_LATCH_EN
                    if (fault_clear) begin
                        fault <= 1'b0;
                        cnt   <= holdoff_lat;
                        state <= S_HOLDOFF;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    qcw_ramp_gen #(
        .FRAC (RAMP_FRAC)
    ) u_ramp (
        .system_clk (system_clk),
        .reset      (reset),
        .load       (state == S_ARM),
        .enable     (state == S_RUN),
        .init       (init_lat),
        .rate       (rate_lat),
        .level      (ramp_raw)
    );

    assign ramp_level = bridge_en ? ramp_raw : '0;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_qcw_pulse_ctrl.sv
// Directed bench for qcw_pulse_ctrl: burst table plus hand-written retrigger, halt and reset sequences.
module tb_qcw_pulse_ctrl;

    logic        system_clk = 1'b0;
    logic        reset      = 1'b1;
    logic        trigger    = 1'b0;
    logic [23:0] pulse_len  = '0;
    logic [23:0] holdoff_len = '0;
    logic [9:0]  ramp_init  = '0;
    logic [7:0]  ramp_rate  = '0;
    logic        qcw_halt   = 1'b0;
    logic        fault_clear = 1'b0;
    logic        qcw_start, qcw_done, bridge_en, busy, fault;
    logic [9:0]  ramp_level;

    int errors = 0;
    int checks = 0;

    always #5 system_clk = ~system_clk;

    qcw_pulse_ctrl dut (
        .system_clk  (system_clk),
        .reset       (reset),
        .trigger     (trigger),
        .pulse_len   (pulse_len),
        .holdoff_len (holdoff_len),
        .ramp_init   (ramp_init),
        .ramp_rate   (ramp_rate),
        .qcw_halt    (qcw_halt),
        .fault_clear (fault_clear),
        .qcw_start   (qcw_start),
        .qcw_done    (qcw_done),
        .bridge_en   (bridge_en),
        .ramp_level  (ramp_level),
        .busy        (busy),
        .fault       (fault)
    );

    typedef struct {
        int plen, hlen, init, rate;
        int e_run, e_dones, e_since, e_first, e_last, e_sat;
    } burst_vec_t;

    burst_vec_t vecs[5];

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_word();
        return int'({qcw_start, qcw_done, bridge_en, busy, fault, ramp_level});
    endfunction

    task automatic fire_and_wait(input string tag);
        int lat;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (qcw_start) break;
        end
        trigger = 1'b0;
        chk({tag, "_start_lat"}, lat, 2);
    endtask

    task automatic run_burst(input burst_vec_t v, input int idx);
        int run, dones, since, first, last, sat, decr, prev;
        bit seen;
        pulse_len   = 24'(v.plen);
        holdoff_len = 24'(v.hlen);
        ramp_init   = 10'(v.init);
        ramp_rate   = 8'(v.rate);
        fire_and_wait($sformatf("v%0d", idx));
        run = 0; dones = 0; since = 0; first = -1; last = -1; sat = 0; decr = 0; prev = -1; seen = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bridge_en) begin
                run++;
                if (run == 1) first = int'(ramp_level);
                if (prev >= 0 && int'(ramp_level) < prev) decr++;
                prev = int'(ramp_level);
                last = int'(ramp_level);
                if (sat == 0 && ramp_level == 10'd1023) sat = run;
            end
            if (seen) since++;
            if (qcw_done) begin
                dones++;
                seen = 1;
            end
            if (!busy) break;
        end
        chk($sformatf("v%0d_idle", idx), int'(busy), 0);
        chk($sformatf("v%0d_run", idx), run, v.e_run);
        chk($sformatf("v%0d_dones", idx), dones, v.e_dones);
        chk($sformatf("v%0d_done_to_idle", idx), since, v.e_since);
        chk($sformatf("v%0d_first_lvl", idx), first, v.e_first);
        chk($sformatf("v%0d_last_lvl", idx), last, v.e_last);
        chk($sformatf("v%0d_sat_cycle", idx), sat, v.e_sat);
        chk($sformatf("v%0d_level_drop", idx), decr, 0);
    endtask

    task automatic halt_burst(input int plen, input int halt_at, input int hlen, input string tag);
        int run, dones, since, starts, flow;
        bit got;
        pulse_len   = 24'(plen);
        holdoff_len = 24'(hlen);
        ramp_init   = 10'd100;
        ramp_rate   = 8'd16;
        fire_and_wait(tag);
        run = 0; dones = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            qcw_halt = 1'b0;
            if (qcw_done) begin
                dones++;
                got = 1;
                chk({tag, "_done_bridge"}, int'(bridge_en), 0);
                chk({tag, "_done_fault"}, int'(fault), 1);
                break;
            end
            if (bridge_en) begin
                run++;
                if (run == halt_at) qcw_halt = 1'b1;
            end
        end
        chk({tag, "_done_seen"}, int'(got), 1);
        chk({tag, "_run"}, run, halt_at);
`ifdef QCW_FAULT_LATCH_EN
        flow = 0; starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) trigger = 1'b1;
            if (i == 10) trigger = 1'b0;
            tick();
            if (!fault || !busy) flow++;
            if (qcw_start) starts++;
            if (qcw_done) dones++;
        end
        chk({tag, "_fault_held"}, flow, 0);
        chk({tag, "_blocked_start"}, starts, 0);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk({tag, "_fault_cleared"}, int'(fault), 0);
        since = 0;
`else
        tick();
        chk({tag, "_fault_pulse_end"}, int'(fault), 0);
        since = 1;
`endif
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick();
            since++;
            if (qcw_done) dones++;
        end
        chk({tag, "_holdoff"}, since, hlen + 1);
        chk({tag, "_dones"}, dones, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int starts, runs, busy_cnt, idle_t, dones;

        vecs[0] = '{100, 50,    0, 8'h00, 100, 1, 51,    0,    0,  0};
        vecs[1] = '{200,  3, 1000, 8'h80, 200, 1,  4, 1000, 1023, 47};
        vecs[2] = '{  1,  0,    5, 8'hFF,   1, 1,  1,    5,    5,  0};
        vecs[3] = '{  3,  2,   10, 8'h40,   3, 1,  3,   10,   10,  0};
        vecs[4] = '{ 10,  1, 1020, 8'hFF,  10, 1,  2, 1020, 1023,  5};

        // Reset with trigger high: outputs clear, and release is not an edge.
        trigger = 1'b1;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("reset_outputs", outs_word(), 0);
        pulse_len = 24'd10;
        reset = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("reset_release_no_edge", busy_cnt, 0);
        trigger = 1'b0;

        // pulse_len == 0 never leaves IDLE.
        pulse_len = '0;
        tick();
        trigger = 1'b1;
        busy_cnt = 0; starts = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (qcw_start) starts++;
        end
        chk("plen0_busy", busy_cnt, 0);
        chk("plen0_start", starts, 0);
        trigger = 1'b0;

        for (int i = 0; i < 5; i++) run_burst(vecs[i], i);

        // Retrigger rules and input latching.
        pulse_len = 24'd20;
        holdoff_len = 24'd10;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        starts = 0; runs = 0; idle_t = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (qcw_start) starts++;
            if (bridge_en) runs++;
            if (!busy && starts > 0 && idle_t == 0) idle_t = t;
            if (t == 3) begin
                pulse_len = 24'd5;
                holdoff_len = 24'd0;
            end
            if (t >= 4 && t <= 30) trigger = (t % 2 == 1);
            else if (t == 31) trigger = 1'b1;
        end
        chk("retrig_starts", starts, 1);
        chk("retrig_run_latched", runs, 20);
        chk("retrig_idle_time", idle_t, 34);
        fire_and_wait("fresh");
        runs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bridge_en) runs++;
            if (!busy) break;
        end
        chk("fresh_run", runs, 5);

        halt_burst(50, 10, 4, "halt");
        halt_burst(5, 5, 2, "halt_last");

        // Reset in RUN cycle 5: everything drops, no qcw_done.
        pulse_len = 24'd50;
        holdoff_len = 24'd5;
        fire_and_wait("rst");
        runs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bridge_en) runs++;
            if (runs == 5) break;
        end
        reset = 1'b1;
        tick();
        chk("rst_mid_outputs", outs_word(), 0);
        reset = 1'b0;
        dones = 0; busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (qcw_done) dones++;
            if (busy) busy_cnt++;
        end
        chk("rst_mid_no_done", dones, 0);
        chk("rst_mid_idle", busy_cnt, 0);
        run_burst(vecs[3], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qcw_pulse_ctrl.md
# qcw_pulse_ctrl

QCW pulse sequencer on `system_clk`. It turns an operator trigger into one bounded QCW burst, issues the `qcw_start`/`qcw_done` strobes that the over-current detector consumes, and gates the bridge. It generates the power-ramp level and aborts on the detector's `qcw_halt`. It enforces a minimum off-time between bursts so duty cycle stays bounded.

## Interface
Parameters:
- `CNT_W`, default 24: width of the pulse and hold-off counters.
- `RAMP_FRAC`, default 8: fractional bits in the ramp accumulator.

Ports:
- `system_clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `trigger` in 1: burst request; only a rising edge counts.
- `pulse_len` in `CNT_W`: burst length in cycles. 0 means disabled.
- `holdoff_len` in `CNT_W`: minimum cycles between the end of one burst and the next `qcw_start`.
- `ramp_init` in 10: ramp level at burst start.
- `ramp_rate` in 8: per-cycle ramp increment, in units of 2^-`RAMP_FRAC`.
- `qcw_halt` in 1: abort from the over-current detector.
- `fault_clear` in 1: clears the latched fault (see Configuration).
- `qcw_start` out 1: one-cycle strobe at burst start.
- `qcw_done` out 1: one-cycle strobe at every burst end.
- `bridge_en` out 1: gate-drive enable; high only in RUN.
- `ramp_level` out 10: current ramp drive level.
- `busy` out 1: high in any state other than IDLE.
- `fault` out 1: sticky over-current fault.

## Operation
States are IDLE, ARM, RUN, HOLDOFF and FAULT.

- **IDLE**
  - Rising edge of `trigger` with `pulse_len != 0` and `fault == 0` goes to ARM.
  - On that transition, `pulse_len`, `holdoff_len`, `ramp_init` and `ramp_rate` are latched. Later input changes do not affect the burst.
- **ARM**
  - Lasts one cycle with `qcw_start = 1`, then goes to RUN.
  - Pulse counter loads `pulse_len - 1`.
  - Accumulator loads `{ramp_init, RAMP_FRAC'b0}`.
- **RUN**
  - `bridge_en = 1`.
  - The accumulator adds `ramp_rate` every cycle and saturates at all-ones, so `ramp_level` never wraps past 1023.
  - The counter decrements.
  - Counter reaching 0 ends the burst. `qcw_done` pulses for one cycle and the state goes to HOLDOFF.
- **Abort in RUN**
  - `qcw_halt == 1` in RUN aborts on that same cycle edge.
  - `qcw_done` pulses and `bridge_en` drops on the next cycle.
  - Next state is FAULT or HOLDOFF, according to Configuration.
  - If `qcw_halt` and counter==0 occur together, this is treated as a halt.
- **HOLDOFF**
  - `bridge_en = 0`, `ramp_level = 0`.
  - Counts the latched `holdoff_len` cycles, then goes to IDLE. `holdoff_len = 0` means exactly one HOLDOFF cycle.
- **FAULT**
  - Outputs idle and `fault = 1`.
  - `fault_clear` goes to HOLDOFF. The hold-off still applies after a fault.
- Trigger edges outside IDLE are dropped, not queued. A level held high through HOLDOFF does not retrigger; a fresh rising edge is required.
- `qcw_halt` outside RUN is ignored.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and the trigger edge register is cleared so a high `trigger` at reset release is not an edge.
- Reset mid-burst drops `bridge_en` on the next edge and does not emit `qcw_done`.
- Latency:
  - Trigger edge to `qcw_start` is 2 cycles: one for the edge register, one for the IDLE→ARM register.
  - `qcw_start` to `bridge_en` high is 1 cycle.
  - `bridge_en` stays high exactly `pulse_len` cycles.
- `qcw_done` is asserted on the cycle after the last `bridge_en` cycle.
- Halt response: the halt sampled at edge N gives `bridge_en = 0` and `qcw_done = 1` in cycle N+1.
- `ramp_level` in the first RUN cycle equals `ramp_init`. It then increments per the accumulator, with the upper 10 bits registered.

## Configuration
Macro: `QCW_FAULT_LATCH_EN`.
- **Defined:** a halt goes to FAULT. `fault` stays set and triggers are blocked until `fault_clear`.
- **Undefined:** a halt goes straight to HOLDOFF. `fault` pulses for the one halt cycle only, and `fault_clear` is unused.

## Structure
- Shared package `qcw_pkg`:
  - state enum `qcw_seq_state_t`
  - `QCW_LEVEL_W = 10`
  - default `CNT_W`
- Sub-module `qcw_ramp_gen` holds the saturating accumulator. Ports: load, enable, init, rate, level.
- Edge detect and the FSM live in the top module.

## Test plan
- **Normal burst:** `pulse_len = 100`, `holdoff_len = 50`, trigger edge → `qcw_start` 2 cycles later, `bridge_en` high for 100 cycles, one `qcw_done`, then `busy` low 51 cycles after `qcw_done`.
- **Ramp:** `ramp_init = 1000`, `ramp_rate = 0x80`, `pulse_len = 200` → `ramp_level` starts at 1000, steps +1 every 2 cycles, and holds at 1023 with no wrap.
- **Over-current halt:** `qcw_halt` asserted on RUN cycle 10 → `bridge_en` low and `qcw_done` high the next cycle.
  - With the macro: `fault` stays latched and a trigger is ignored until `fault_clear`.
  - Without it: `fault` pulses for one cycle and the block goes to HOLDOFF.
- **Retrigger rules:** trigger edges during RUN and HOLDOFF give no extra burst. `trigger` held high after a burst gives no retrigger. A fresh edge after IDLE gives a burst. `pulse_len = 0` never leaves IDLE.
- **Reset mid-RUN:** `reset` at RUN cycle 5 → all outputs 0 the next cycle, no `qcw_done`, IDLE; a later trigger works normally.
- **Simultaneous halt and counter expiry:** halt and counter==0 on the same cycle → one `qcw_done`, halt path taken.
